// File: rtl/mul_approx_pipe.sv
// Pipelined unsigned WIDTH x WIDTH multiplier with per-transaction exact/truncated mode.
// Optional error-centering bias on approximate results: define MUL_APPROX_BIAS_COMP_EN.
module mul_approx_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned TRUNC  = 4,
  parameter int unsigned STAGES = 3
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 MODE,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   O,
  output logic                 OUT_MODE,
  output logic [15:0]          APPROX_CNT
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef logic [PW-1:0]    word_t;
  typedef word_t [WIDTH-1:0] rows_t;

`ifdef MUL_APPROX_BIAS_COMP_EN
  localparam int unsigned BiasSh = (TRUNC > 0) ? TRUNC - 1 : 0;
  localparam word_t       Bias   = word_t'(1) << BiasSh;
`endif

  // Middle stage that folds partial-product row i into the running sum in row 0.
  function automatic int stage_of(input int i);
    int div;
    div = (WIDTH > 1) ? int'(WIDTH) - 1 : 1;
    if (STAGES == 1 || i == 0) return 0;
    return 1 + ((i - 1) * (int'(STAGES) - 1)) / div;
  endfunction

  function automatic rows_t fold(input rows_t src, input int k);
    rows_t r;
    word_t acc;
    r   = src;
    acc = src[0];
    for (int i = 1; i < int'(WIDTH); i++) begin
      if (stage_of(i) == k) begin
        acc  = acc + src[i];
        r[i] = '0;
      end
    end
    r[0] = acc;
    return r;
  endfunction

  // Rows already folded are zero, so the final stage can simply add everything left.
  function automatic word_t sum_rows(input rows_t src);
    word_t acc;
    acc = '0;
    for (int i = 0; i < int'(WIDTH); i++) acc = acc + src[i];
    return acc;
  endfunction

  logic [STAGES-1:0] valid_q, mode_q;
  logic [STAGES-1:0] src_valid, src_mode;
  logic [STAGES:0]   ready;
  rows_t             pp, last_src;
  word_t             mask, last_word, prod_q;
  logic [15:0]       approx_cnt_q;

  always_comb begin
    ready[STAGES] = OUT_READY;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
    src_valid[0] = IN_VALID;
    src_mode[0]  = MODE;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_valid[k] = valid_q[k-1];
      src_mode[k]  = mode_q[k-1];
    end
  end

  // Column masking drops exactly the terms a_i*b_j with i+j < TRUNC.
  always_comb begin
    mask = MODE ? ~((word_t'(1) << TRUNC) - word_t'(1)) : '1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      pp[i] = B[i] ? ((word_t'(A) << i) & mask) : '0;
    end
  end

  if (STAGES > 1) begin : g_pipe
    rows_t rows_q [STAGES-1];

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        for (int k = 0; k < int'(STAGES) - 1; k++) rows_q[k] <= '0;
      end else begin
        if (ready[0] && IN_VALID) rows_q[0] <= pp;
        for (int k = 1; k < int'(STAGES) - 1; k++) begin
          if (ready[k] && valid_q[k-1]) rows_q[k] <= fold(rows_q[k-1], k);
        end
      end
    end

    assign last_src = rows_q[STAGES-2];
  end else begin : g_single
    assign last_src = pp;
  end

  always_comb begin
    last_word = sum_rows(last_src);
`ifdef MUL_APPROX_BIAS_COMP_EN
    if (TRUNC > 0 && src_mode[STAGES-1]) begin
      logic [PW:0] wide;
      wide      = {1'b0, last_word} + {1'b0, Bias};
      last_word = wide[PW] ? '1 : wide[PW-1:0];
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q      <= '0;
      mode_q       <= '0;
      prod_q       <= '0;
      approx_cnt_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) mode_q[k] <= src_mode[k];
        end
      end
      if (ready[STAGES-1] && src_valid[STAGES-1]) prod_q <= last_word;
      if (OUT_VALID && OUT_READY && OUT_MODE && approx_cnt_q != 16'hFFFF) begin
        approx_cnt_q <= approx_cnt_q + 16'd1;
      end
    end
  end

  assign IN_READY   = ready[0];
  assign OUT_VALID  = valid_q[STAGES-1];
  assign OUT_MODE   = mode_q[STAGES-1];
  assign O          = prod_q;
  assign APPROX_CNT = approx_cnt_q;

endmodule

// File: tb/tb_mul_approx_pipe.sv
// Directed-vector bench for mul_approx_pipe plus a randomised 12-bit sweep against a column model.
// Expected values follow MUL_APPROX_BIAS_COMP_EN when defined.
module tb_mul_approx_pipe;

`ifdef MUL_APPROX_BIAS_COMP_EN
  localparam bit BiasOn = 1'b1;
`else
  localparam bit BiasOn = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  // 8-bit default instance
  logic        in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready = 1'b1, out_mode;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] o, approx_cnt;

  // 12-bit instances share stimulus; u_dut0 has TRUNC=0
  logic        v12 = 1'b0, r12, m12 = 1'b0, ov12, or12 = 1'b1, om12;
  logic [11:0] a12 = '0, b12 = '0;
  logic [23:0] o12, o0;
  logic        r0, ov0, om0;
  logic [15:0] cnt12, cnt0;

  mul_approx_pipe #(.WIDTH(8), .TRUNC(4), .STAGES(3)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b),
    .MODE(mode), .OUT_VALID(out_valid), .OUT_READY(out_ready), .O(o), .OUT_MODE(out_mode),
    .APPROX_CNT(approx_cnt)
  );

  mul_approx_pipe #(.WIDTH(12), .TRUNC(7), .STAGES(4)) u_dut12 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(v12), .IN_READY(r12), .A(a12), .B(b12),
    .MODE(m12), .OUT_VALID(ov12), .OUT_READY(or12), .O(o12), .OUT_MODE(om12),
    .APPROX_CNT(cnt12)
  );

  mul_approx_pipe #(.WIDTH(12), .TRUNC(0), .STAGES(4)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(v12), .IN_READY(r0), .A(a12), .B(b12),
    .MODE(m12), .OUT_VALID(ov0), .OUT_READY(or12), .O(o0), .OUT_MODE(om0),
    .APPROX_CNT(cnt0)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got no event, expected one within bound", name);
  endtask

  function automatic longint ref_mul(input longint x, input longint y, input int w,
                                     input int trunc, input bit m);
    longint s = 0;
    longint mx;
    for (int i = 0; i < w; i++)
      for (int j = 0; j < w; j++)
        if (x[i] && y[j] && (!m || i + j >= trunc)) s += longint'(1) << (i + j);
    if (BiasOn && m && trunc > 0) s += longint'(1) << (trunc - 1);
    mx = (longint'(1) << (2 * w)) - 1;
    if (s > mx) s = mx;
    return s;
  endfunction

  typedef struct {
    longint o;
    bit     m;
  } exp_t;

  exp_t q8[$];
  exp_t e8;

  typedef struct {
    longint ap;
    longint ex0;
    longint ex;
    bit     m;
  } exp12_t;

  exp12_t q12[$];
  exp12_t e12;

  always @(negedge CLK) begin
    if (!RST_N) begin
      q8.delete();
    end else if (out_valid && out_ready) begin
      if (q8.size() == 0) begin
        fail_now("dut8_unexpected_output");
      end else begin
        e8 = q8.pop_front();
        check("dut8_o", longint'(o), e8.o);
        check("dut8_out_mode", longint'(out_mode), longint'(e8.m));
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST_N) begin
      q12.delete();
    end else begin
      if (v12 && r12) begin
        e12.ap  = ref_mul(longint'(a12), longint'(b12), 12, 7, m12);
        e12.ex0 = ref_mul(longint'(a12), longint'(b12), 12, 0, m12);
        e12.ex  = longint'(a12) * longint'(b12);
        e12.m   = m12;
        q12.push_back(e12);
      end
      if (ov12 && or12) begin
        if (q12.size() == 0) begin
          fail_now("dut12_unexpected_output");
        end else begin
          e12 = q12.pop_front();
          check("dut12_o", longint'(o12), e12.ap);
          check("dut12_out_mode", longint'(om12), longint'(e12.m));
          check("dut0_valid", longint'(ov0), 1);
          check("dut0_trunc0_equals_exact", longint'(o0), e12.ex0);
          if (!BiasOn && om12) check("approx_le_exact", (longint'(o12) <= e12.ex) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds the request until accepted, then queues the expected result.
  task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic sm,
                      input longint exp);
    exp_t e;
    int w = 0;
    in_valid = 1'b1;
    a = sa;
    b = sb;
    mode = sm;
    @(negedge CLK);
    while (!in_ready && w < 50) begin
      @(negedge CLK);
      w++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
    end else begin
      e.o = exp;
      e.m = sm;
      q8.push_back(e);
    end
    tick();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    longint     o;
  } vec_t;

  vec_t tab[10];

  initial begin
    int cyc;
    int acc;
    int napprox;

    tab[0] = '{8'd255, 8'd255, 1'b0, 65025};
    tab[1] = '{8'd3,   8'd3,   1'b1, BiasOn ? 8     : 0};
    tab[2] = '{8'd16,  8'd16,  1'b1, BiasOn ? 264   : 256};
    tab[3] = '{8'd255, 8'd255, 1'b1, BiasOn ? 64984 : 64976};
    tab[4] = '{8'd0,   8'd200, 1'b1, BiasOn ? 8     : 0};
    tab[5] = '{8'd15,  8'd15,  1'b1, BiasOn ? 184   : 176};
    tab[6] = '{8'd12,  8'd10,  1'b0, 120};
    tab[7] = '{8'd12,  8'd10,  1'b1, BiasOn ? 120   : 112};
    tab[8] = '{8'd1,   8'd1,   1'b0, 1};
    tab[9] = '{8'd128, 8'd255, 1'b1, BiasOn ? 32648 : 32640};

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_o", longint'(o), 0);
    check("reset_out_mode", longint'(out_mode), 0);
    check("reset_approx_cnt", longint'(approx_cnt), 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("in_ready_after_reset", longint'(in_ready), 1);
    tick();

    // Exact latency
    send(8'd255, 8'd255, 1'b0, 65025);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("latency_cycles", cyc, 3);
    repeat (3) tick();

    // Approximate 255x255 and counter
    send(8'd255, 8'd255, 1'b1, BiasOn ? 64984 : 64976);
    in_valid = 1'b0;
    repeat (5) tick();
    check("approx_cnt_one", longint'(approx_cnt), 1);

    // Table stream, back to back
    napprox = 0;
    for (int i = 0; i < 10; i++) begin
      send(tab[i].a, tab[i].b, tab[i].m, tab[i].o);
      if (tab[i].m) napprox++;
    end
    in_valid = 1'b0;
    repeat (8) tick();
    check("approx_cnt_after_table", longint'(approx_cnt), longint'(1 + napprox));
    check("table_all_delivered", longint'(q8.size()), 0);

    // Backpressure: only three fit
    out_ready = 1'b0;
    acc = 0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1;
      a = 8'(k);
      b = 8'd10;
      mode = 1'b0;
      @(negedge CLK);
      if (in_ready) begin
        acc++;
        e8.o = longint'(k * 10);
        e8.m = 1'b0;
        q8.push_back(e8);
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge CLK);
    check("bp_accepted", acc, 3);
    check("bp_in_ready", longint'(in_ready), 0);
    check("bp_out_valid_held", longint'(out_valid), 1);
    check("bp_o_held", longint'(o), 10);
    tick();
    out_ready = 1'b1;
    send(8'd4, 8'd10, 1'b0, 40);
    send(8'd5, 8'd10, 1'b0, 50);
    in_valid = 1'b0;
    repeat (6) tick();
    check("bp_all_delivered", longint'(q8.size()), 0);

    // Asynchronous reset with two in flight
    send(8'd2, 8'd3, 1'b0, 6);
    send(8'd5, 8'd5, 1'b1, 0);
    in_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_o", longint'(o), 0);
    check("rst_approx_cnt", longint'(approx_cnt), 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("no_stale_output", longint'(out_valid), 0);
    end
    check("in_ready_after_mid_reset", longint'(in_ready), 1);
    tick();

    // Random 12-bit sweep with output stalls
    for (int i = 0; i < 400; i++) begin
      v12 = ($urandom_range(0, 3) != 0);
      a12 = 12'($urandom);
      b12 = 12'($urandom);
      if (i % 50 == 0) begin
        a12 = 12'hFFF;
        b12 = 12'hFFF;
      end
      m12 = 1'($urandom_range(0, 1));
      or12 = ($urandom_range(0, 3) != 0);
      tick();
    end
    v12 = 1'b0;
    or12 = 1'b1;
    repeat (10) tick();
    check("sweep_all_delivered", longint'(q12.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
